// File: rtl/ble_slot_mon.sv
// ble_slot_mon: BLE connection-event slot monitor.
// Tracks the TX / TIFS / RX / TIFS strobe sequence of a connection event,
// checks window and gap lengths, flags ordering and overlap errors, and
// advances the data-channel hop index once per completed event.
// Build option: define BLE_SLOT_MON_STICKY_EN for sticky error flags with
// clr_err; without it err_flags reads 0 and clr_err has no effect.
//
// state  | meaning
// IDLE   | waiting for the first-window strobe of an event
// FIRST  | first window of the event is high (TX when role=1, RX when role=0)
// GAP1   | TIFS gap between first and second window
// SECOND | second window of the event is high (RX when role=1, TX when role=0)
// GAP2   | TIFS gap closing the event; next first-window strobe completes it
module ble_slot_mon #(
    parameter int TX_RX_COUNT = 625,
    parameter int TIFS_COUNT  = 150,
    parameter int HOP_INC     = 7
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        ble_tx,
    input  logic        ble_rx,
    input  logic        ble_tifs,
    input  logic        tx_flag,
    input  logic        clr_err,
    output logic [2:0]  phase,
    output logic [5:0]  channel_index,
    output logic        event_done,
    output logic [15:0] event_cnt,
    output logic        err_len,
    output logic        err_order,
    output logic        err_overlap,
    output logic [2:0]  err_flags
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FIRST  = 3'd1;
    localparam logic [2:0] S_GAP1   = 3'd2;
    localparam logic [2:0] S_SECOND = 3'd3;
    localparam logic [2:0] S_GAP2   = 3'd4;

    localparam logic [9:0] WIN_LEN  = 10'(TX_RX_COUNT);
    localparam logic [9:0] GAP_LEN  = 10'(TIFS_COUNT);
    localparam logic [9:0] LEN_MAX  = 10'd1023;
    localparam logic [6:0] HOP      = 7'(HOP_INC);
    localparam logic [6:0] NUM_CH   = 7'd37;

    logic [2:0]  state, state_n;
    logic        role, role_n;
    logic [9:0]  len_cnt, len_n;
    logic [5:0]  chan_n;
    logic [15:0] cnt_n;
    logic        done_n, len_e, ord_e, ovl_e;

    logic [1:0]  num_high;
    logic        overlap;
    logic        first_stb, second_stb, idle_first;
    logic        act_stb, nxt_stb;
    logic [9:0]  req_len;
    logic [2:0]  adv_state;
    logic [6:0]  hop_sum, hop_wrap;
    logic        unused_bits;

    assign num_high   = {1'b0, ble_tx} + {1'b0, ble_rx} + {1'b0, ble_tifs};
    assign overlap    = (num_high >= 2'd2);
    assign first_stb  = role ? ble_tx : ble_rx;
    assign second_stb = role ? ble_rx : ble_tx;
    assign idle_first = tx_flag ? ble_tx : ble_rx;

    // Hop index stays below 37, so one conditional subtract is always enough.
    assign hop_sum     = {1'b0, channel_index} + HOP;
    assign hop_wrap    = hop_sum - NUM_CH;
    assign unused_bits = ^{hop_wrap[6], clr_err};

    // Per-state view: which strobe holds the state, which one hands off, target length.
    always_comb begin
        act_stb   = 1'b0;
        nxt_stb   = 1'b0;
        req_len   = WIN_LEN;
        adv_state = S_IDLE;
        case (state)
            S_FIRST: begin
                act_stb   = first_stb;
                nxt_stb   = ble_tifs;
                req_len   = WIN_LEN;
                adv_state = S_GAP1;
            end
            S_GAP1: begin
                act_stb   = ble_tifs;
                nxt_stb   = second_stb;
                req_len   = GAP_LEN;
                adv_state = S_SECOND;
            end
            S_SECOND: begin
                act_stb   = second_stb;
                nxt_stb   = ble_tifs;
                req_len   = WIN_LEN;
                adv_state = S_GAP2;
            end
            S_GAP2: begin
                act_stb   = ble_tifs;
                nxt_stb   = first_stb;
                req_len   = GAP_LEN;
                adv_state = S_FIRST;
            end
            default: begin
                act_stb   = 1'b0;
                nxt_stb   = 1'b0;
                req_len   = WIN_LEN;
                adv_state = S_IDLE;
            end
        endcase
    end

    // Next-state, length counter, event bookkeeping and error pulse decode.
    always_comb begin
        state_n = state;
        role_n  = role;
        len_n   = len_cnt;
        chan_n  = channel_index;
        cnt_n   = event_cnt;
        done_n  = 1'b0;
        len_e   = 1'b0;
        ord_e   = 1'b0;
        ovl_e   = 1'b0;
        if (state == S_IDLE) begin
            if (overlap) begin
                ovl_e = 1'b1;
            end else if (idle_first) begin
                role_n  = tx_flag;
                len_n   = 10'd1;
                state_n = S_FIRST;
            end else if (num_high != 2'd0) begin
                ord_e = 1'b1;
            end
        end else if ((state == S_FIRST) || (state == S_GAP1) ||
                     (state == S_SECOND) || (state == S_GAP2)) begin
            if (overlap) begin
                ovl_e   = 1'b1;
                len_n   = 10'd0;
                state_n = S_IDLE;
            end else if (act_stb) begin
                len_n = (len_cnt == LEN_MAX) ? LEN_MAX : len_cnt + 10'd1;
            end else if (nxt_stb) begin
                len_e   = (len_cnt != req_len);
                len_n   = 10'd1;
                state_n = adv_state;
                if (state == S_GAP2) begin
                    done_n = 1'b1;
                    cnt_n  = event_cnt + 16'd1;
                    chan_n = (hop_sum >= NUM_CH) ? hop_wrap[5:0] : hop_sum[5:0];
                end
            end else begin
                ord_e   = 1'b1;
                len_n   = 10'd0;
                state_n = S_IDLE;
            end
        end else begin
            len_n   = 10'd0;
            state_n = S_IDLE;
        end
    end

    // State, counters and pulse outputs; reset wins over every input.
    always_ff @(posedge clock) begin
        if (rst) begin
            state         <= S_IDLE;
            role          <= 1'b0;
            len_cnt       <= 10'd0;
            channel_index <= 6'd0;
            event_cnt     <= 16'd0;
            event_done    <= 1'b0;
            err_len       <= 1'b0;
            err_order     <= 1'b0;
            err_overlap   <= 1'b0;
        end else begin
            state         <= state_n;
            role          <= role_n;
            len_cnt       <= len_n;
            channel_index <= chan_n;
            event_cnt     <= cnt_n;
            event_done    <= done_n;
            err_len       <= len_e;
            err_order     <= ord_e;
            err_overlap   <= ovl_e;
        end
    end

    assign phase = state;

`ifdef BLE_SLOT_MON_STICKY_EN
    // Sticky flags rise together with their pulse; a new error beats clr_err.
    always_ff @(posedge clock) begin
        if (rst) begin
            err_flags <= 3'b000;
        end else begin
            err_flags <= (err_flags & ~{3{clr_err}}) | {ovl_e, ord_e, len_e};
        end
    end
`else
    assign err_flags = 3'b000;
`endif

endmodule

// File: tb/tb_ble_slot_mon.sv
// tb_ble_slot_mon: directed-vector bench for ble_slot_mon (default parameters).
module tb_ble_slot_mon;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        ble_tx = 1'b0, ble_rx = 1'b0, ble_tifs = 1'b0;
    logic        tx_flag = 1'b1, clr_err = 1'b0;
    logic [2:0]  phase;
    logic [5:0]  channel_index;
    logic        event_done;
    logic [15:0] event_cnt;
    logic        err_len, err_order, err_overlap;
    logic [2:0]  err_flags;

    int n_cmp = 0;
    int n_bad = 0;
    int c_done = 0, c_len = 0, c_ord = 0, c_ovl = 0;

`ifdef BLE_SLOT_MON_STICKY_EN
    localparam int ORD_FLAG = 2;
`else
    localparam int ORD_FLAG = 0;
`endif

    ble_slot_mon dut (
        .clock(clock), .rst(rst),
        .ble_tx(ble_tx), .ble_rx(ble_rx), .ble_tifs(ble_tifs),
        .tx_flag(tx_flag), .clr_err(clr_err),
        .phase(phase), .channel_index(channel_index),
        .event_done(event_done), .event_cnt(event_cnt),
        .err_len(err_len), .err_order(err_order), .err_overlap(err_overlap),
        .err_flags(err_flags)
    );

    always #5 clock = ~clock;

    // Pulse tallies, sampled mid-cycle.
    always @(negedge clock) begin
        if (event_done)  c_done++;
        if (err_len)     c_len++;
        if (err_order)   c_ord++;
        if (err_overlap) c_ovl++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Hold a strobe pattern for n cycles; returns just after a falling edge.
    task automatic seg(input logic t, input logic r, input logic f, input int n);
        for (int i = 0; i < n; i++) begin
            ble_tx = t; ble_rx = r; ble_tifs = f;
            @(negedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        seg(1'b0, 1'b0, 1'b0, 2);
        rst = 1'b0;
    endtask

    int hop_exp[6] = '{7, 14, 21, 28, 35, 5};
    int s_len, s_ord, s_ovl, s_done;

    initial begin
        // Reset state
        seg(1'b0, 1'b0, 1'b0, 2);
        chk("rst_phase", phase, 0);
        chk("rst_chan", channel_index, 0);
        chk("rst_cnt", event_cnt, 0);
        chk("rst_pulses", {event_done, err_len, err_order, err_overlap}, 0);
        chk("rst_flags", err_flags, 0);
        rst = 1'b0;

        // TX-first nominal events, six back to back
        tx_flag = 1'b1;
        for (int i = 0; i < 6; i++) begin
            seg(1'b1, 1'b0, 1'b0, (i == 0) ? 625 : 624);
            seg(1'b0, 1'b0, 1'b1, 150);
            seg(1'b0, 1'b1, 1'b0, 625);
            seg(1'b0, 1'b0, 1'b1, 150);
            seg(1'b1, 1'b0, 1'b0, 1);
            chk("ev_done", event_done, 1);
            chk("ev_cnt", event_cnt, i + 1);
            chk("ev_chan", channel_index, hop_exp[i]);
            if (i == 0) begin
                chk("ev1_done_tally", c_done, 1);
                chk("ev1_phase", phase, 1);
            end
        end
        chk("nominal_done_tally", c_done, 6);
        chk("nominal_err_tally", c_len + c_ord + c_ovl, 0);

        // RX-first, short TX second window; tx_flag flips mid-event
        do_reset();
        tx_flag = 1'b0;
        s_len = c_len; s_done = c_done;
        seg(1'b0, 1'b1, 1'b0, 625);
        tx_flag = 1'b1;
        seg(1'b0, 0, 1'b1, 150);
        seg(1'b1, 1'b0, 1'b0, 624);
        chk("short_no_early_len", c_len - s_len, 0);
        seg(1'b0, 1'b0, 1'b1, 1);
        chk("short_len_pulse", err_len, 1);
        seg(1'b0, 1'b0, 1'b1, 149);
        seg(1'b0, 1'b1, 1'b0, 1);
        chk("short_len_tally", c_len - s_len, 1);
        chk("short_done", event_done, 1);
        chk("short_cnt", event_cnt, 1);
        chk("short_chan", channel_index, 7);

        // Overlap in FIRST aborts without touching count or channel
        s_ord = c_ord;
        seg(1'b1, 1'b0, 1'b1, 1);
        chk("ovl_pulse", err_overlap, 1);
        chk("ovl_phase", phase, 0);
        chk("ovl_no_order", c_ord - s_ord, 0);
        chk("ovl_cnt", event_cnt, 1);
        chk("ovl_chan", channel_index, 7);

        // Stray TIFS in IDLE is an order error
        seg(1'b0, 1'b0, 1'b1, 1);
        chk("idle_order", err_order, 1);
        chk("idle_phase", phase, 0);
        seg(1'b0, 1'b0, 1'b0, 1);
        clr_err = 1'b1;
        seg(1'b0, 1'b0, 1'b0, 1);
        clr_err = 1'b0;

        // TX falls with no TIFS following
        tx_flag = 1'b1;
        seg(1'b1, 1'b0, 1'b0, 625);
        seg(1'b0, 1'b0, 1'b0, 1);
        chk("ord_pulse", err_order, 1);
        chk("ord_phase", phase, 0);
        chk("ord_flags", err_flags, ORD_FLAG);
        chk("ord_cnt", event_cnt, 1);
        seg(1'b0, 1'b0, 1'b0, 3);
        chk("ord_pulse_gone", err_order, 0);
        chk("ord_flags_hold", err_flags, ORD_FLAG);
        clr_err = 1'b1;
        seg(1'b0, 1'b0, 1'b0, 1);
        clr_err = 1'b0;
        chk("ord_flags_clr", err_flags, 0);

        // Reset in SECOND
        seg(1'b1, 1'b0, 1'b0, 625);
        seg(1'b0, 1'b0, 1'b1, 150);
        seg(1'b0, 1'b1, 1'b0, 10);
        chk("mid_phase", phase, 3);
        s_len = c_len; s_ord = c_ord; s_ovl = c_ovl;
        rst = 1'b1;
        seg(1'b0, 1'b1, 1'b0, 1);
        chk("rst2_phase", phase, 0);
        chk("rst2_chan", channel_index, 0);
        chk("rst2_cnt", event_cnt, 0);
        chk("rst2_pulses", {event_done, err_len, err_order, err_overlap}, 0);
        chk("rst2_flags", err_flags, 0);
        rst = 1'b0;
        seg(1'b0, 1'b0, 1'b0, 2);
        chk("rst2_no_err", (c_len - s_len) + (c_ord - s_ord) + (c_ovl - s_ovl), 0);
        chk("rst2_idle", phase, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
